// File: rtl/parity_uart_tx.sv
// parity_uart_tx: framed serial transmitter with even parity.
//
// Takes a parallel word over a valid/ready handshake, latches it, and sends
// start bit (0), data bits LSB first, even parity bit, then stop bit (1).
// Every serial bit is held for CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any frame in flight
//   di        word to transmit, sampled only on handshake
//   di_valid  producer has a word on di
//   di_ready  block can accept a word this cycle (IDLE and not in reset)
//   tx        serial line, idles high (registered)
//   busy      frame in progress (state other than IDLE)
//   done      one-cycle pulse on the final cycle of the stop bit (registered)

// parity: even-parity generator; p makes the total count of ones even.
module parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    output logic             p
);
    assign p = ^d;
endmodule

module parity_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  di_valid,
    output logic                  di_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // Count value one before the last cycle of a bit; only meaningful when
    // CLKS_PER_BIT > 1.
    localparam logic [CW-1:0] CNT_PRE  = CW'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] sh_next;
    logic                  par_bit;
    logic                  di_par;
    logic                  cnt_last;

    parity #(.WIDTH(DATA_WIDTH)) u_parity (
        .d (di),
        .p (di_par)
    );

    assign di_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign cnt_last = (cnt == CNT_LAST);
    // Drive tx from the shifted value so DATA_WIDTH=1 never indexes bit 1.
    assign sh_next  = shreg >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            done    <= 1'b0;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx     <= 1'b1;
                    cnt    <= '0;
                    bitcnt <= '0;
                    if (di_valid) begin
                        shreg   <= di;
                        par_bit <= di_par;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bitcnt == BIT_LAST) begin
                            bitcnt <= '0;
                            tx     <= par_bit;
                            state  <= PARITY;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            shreg  <= sh_next;
                            tx     <= sh_next[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                        // With single-cycle bits the first stop cycle is also the last.
                        done  <= (CLKS_PER_BIT == 1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // done is registered, so raise it entering the last stop cycle.
                        if (cnt == CNT_PRE) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
